// File: rtl/conv_3x3_filter.sv
// 3x3 window convolution over a streamed 3-row pixel column. The kernel is selected at
// runtime and the output is a clamped 8-bit pixel tagged with its window-centre coordinates.
module conv_3x3_filter #(
    parameter int HRES = 640,
    parameter int VRES = 380
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [2:0][7:0] data_in,
    input  logic [10:0]     hcount_in,
    input  logic [9:0]      vcount_in,
    input  logic            data_valid_in,
    input  logic [2:0]      sel_in,
    output logic [7:0]      pixel_out,
    output logic [10:0]     hcount_out,
    output logic [9:0]      vcount_out,
    output logic            data_valid_out
);
    localparam logic [10:0] H_LAST = 11'(HRES - 1);
    localparam logic [9:0]  V_LAST = 10'(VRES - 1);

    typedef enum logic [2:0] {
        K_IDENT = 3'd0,
        K_GAUSS = 3'd1,
        K_SHARP = 3'd2,
        K_SOBX  = 3'd3,
        K_SOBY  = 3'd4,
        K_SOBXY = 3'd5
    } kernel_e;

    typedef struct packed {
        logic        valid;
        logic        border;
        logic [10:0] h;
        logic [9:0]  v;
    } tag_t;

    function automatic logic signed [11:0] zx8(input logic [7:0] x);
        return $signed({4'b0000, x});
    endfunction

    function automatic logic signed [11:0] zx10(input logic [9:0] x);
        return $signed({2'b00, x});
    endfunction

    function automatic logic signed [11:0] sx9(input logic [8:0] x);
        return $signed({{3{x[8]}}, x});
    endfunction

    function automatic logic signed [11:0] abs12(input logic signed [11:0] x);
        return x[11] ? -x : x;
    endfunction

    // Window columns, kernel latch and pending end-of-line beat
    logic [2:0][7:0] col_l_q, col_c_q, col_r_q;
    logic [2:0]      sel_q, sel_d;
    logic            pend_q, pend_d;
    logic [9:0]      pend_v_q, pend_v_d;
    logic [10:0]     centre_h;

    // Pipeline stages
    tag_t                s1_q, s1_d;
    tag_t                s2_q, s3_q;
    logic [2:0]          s2_sel_q;
    logic [2:0][9:0]     g_q, g_d;
    logic [2:0][8:0]     dx_q, dx_d;
    logic [2:0][7:0]     b_q, b_d;
    logic signed [11:0]  sp_q, sp_d;
    logic [11:0]         gsum;
    logic signed [11:0]  gx, gy, sharp, val;
    logic signed [11:0]  s3_val_q;

    // Output registers
    logic [7:0]  pix_q, pix_d;
    logic [10:0] hcount_q;
    logic [9:0]  vcount_q;
    logic        valid_q;

    assign centre_h = hcount_in - 11'd1;

    // S1: the injected end-of-line beat has priority over any beat arriving with it.
    always_comb begin
        // NOTE: every _d gets its default before any branch, so no path can leave
        // a combinational signal unassigned and infer a latch.
        s1_d     = '0;
        pend_d   = data_valid_in && (hcount_in == H_LAST);
        pend_v_d = pend_d ? vcount_in : pend_v_q;
        sel_d    = sel_q;
        if (data_valid_in && hcount_in == 11'd0 && vcount_in == 10'd0)
            sel_d = sel_in;
        if (pend_q) begin
            s1_d.valid  = 1'b1;
            s1_d.border = 1'b1;
            s1_d.h      = H_LAST;
            s1_d.v      = pend_v_q;
        end else if (data_valid_in && hcount_in != 11'd0) begin
            s1_d.valid  = 1'b1;
            s1_d.h      = centre_h;
            s1_d.v      = vcount_in;
            s1_d.border = (centre_h == 11'd0) || (centre_h == H_LAST) ||
                          (vcount_in == 10'd0) || (vcount_in == V_LAST);
        end
    end

    // S2: per-row partials. g = a+2b+c serves gaussian and sobel-y, dx = c-a serves sobel-x.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            g_d[r]  = {2'b00, col_l_q[r]} + {1'b0, col_c_q[r], 1'b0} + {2'b00, col_r_q[r]};
            dx_d[r] = {1'b0, col_r_q[r]} - {1'b0, col_l_q[r]};
            b_d[r]  = col_c_q[r];
        end
        sp_d = (zx8(col_c_q[1]) <<< 2) + zx8(col_c_q[1]) - zx8(col_l_q[1]) - zx8(col_r_q[1]);
    end

    // S3: combine rows for the selected kernel.
    always_comb begin
        gsum  = {2'b00, g_q[0]} + {1'b0, g_q[1], 1'b0} + {2'b00, g_q[2]};
        gx    = sx9(dx_q[0]) + (sx9(dx_q[1]) <<< 1) + sx9(dx_q[2]);
        gy    = zx10(g_q[2]) - zx10(g_q[0]);
        sharp = sp_q - zx8(b_q[0]) - zx8(b_q[2]);
        case (s2_sel_q)
            K_GAUSS: val = $signed(gsum >> 4);
            K_SHARP: val = sharp;
            K_SOBX:  val = abs12(gx);
            K_SOBY:  val = abs12(gy);
            K_SOBXY: val = abs12(gx) + abs12(gy);
            default: val = zx8(b_q[1]);
        endcase
    end

    always_comb begin
        pix_d = 8'd0;
        if (s3_q.valid && !s3_q.border) begin
            if (s3_val_q[11])
                pix_d = 8'd0;
            else if (s3_val_q > 12'sd255)
                pix_d = 8'd255;
            else
                pix_d = s3_val_q[7:0];
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every register sees
    // pre-edge values. The datapath is reset too, so a reset cannot release stale pixels.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            col_l_q  <= '0;
            col_c_q  <= '0;
            col_r_q  <= '0;
            sel_q    <= '0;
            pend_q   <= 1'b0;
            pend_v_q <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s2_sel_q <= '0;
            g_q      <= '0;
            dx_q     <= '0;
            b_q      <= '0;
            sp_q     <= '0;
            s3_q     <= '0;
            s3_val_q <= '0;
            pix_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (data_valid_in) begin
                col_l_q <= col_c_q;
                col_c_q <= col_r_q;
                col_r_q <= data_in;
            end
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            s1_q     <= s1_d;
            s2_q     <= s1_q;
            s2_sel_q <= sel_q;
            g_q      <= g_d;
            dx_q     <= dx_d;
            b_q      <= b_d;
            sp_q     <= sp_d;
            s3_q     <= s2_q;
            s3_val_q <= val;
            pix_q    <= pix_d;
            hcount_q <= s3_q.h;
            vcount_q <= s3_q.v;
            valid_q  <= s3_q.valid;
        end
    end

    assign pixel_out      = pix_q;
    assign hcount_out     = hcount_q;
    assign vcount_out     = vcount_q;
    assign data_valid_out = valid_q;

endmodule

// File: tb/tb_conv_3x3_filter.sv
// Scoreboard bench for conv_3x3_filter at HRES=8, VRES=6. Directed frames carry hand-derived
// pixel values, and every output beat is also checked against its exact expected cycle.
`timescale 1ns/1ps
module tb_conv_3x3_filter;
    localparam int HRES = 8;
    localparam int VRES = 6;

    typedef enum int {IMG_CONST100, IMG_FLAT80, IMG_IMPULSE, IMG_INV_IMPULSE, IMG_RAMP} img_e;
    typedef struct { int h; int v; int pix; int cyc; } exp_t;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [2:0][7:0] data_in;
    logic [10:0]     hcount_in;
    logic [9:0]      vcount_in;
    logic            data_valid_in;
    logic [2:0]      sel_in;
    logic [7:0]      pixel_out;
    logic [10:0]     hcount_out;
    logic [9:0]      vcount_out;
    logic            data_valid_out;

    conv_3x3_filter #(.HRES(HRES), .VRES(VRES)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
        .sel_in(sel_in), .pixel_out(pixel_out), .hcount_out(hcount_out),
        .vcount_out(vcount_out), .data_valid_out(data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         n_out  = 0;
    int         n_mark;
    logic [2:0] frame_sel;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int img(input img_e k, input int h, input int v);
        case (k)
            IMG_CONST100:    return 100;
            IMG_FLAT80:      return 80;
            IMG_IMPULSE:     return (h == 3 && v == 3) ? 255 : 0;
            IMG_INV_IMPULSE: return (h == 3 && v == 3) ? 0 : 255;
            default:         return 10 * h;
        endcase
    endfunction

    // Hand-derived results for the image/kernel pairs exercised below.
    function automatic int expect_px(input img_e k, input logic [2:0] sel, input int h, input int v);
        int ah, av;
        ah = (h > 3) ? h - 3 : 3 - h;
        av = (v > 3) ? v - 3 : 3 - v;
        if (h == 0 || h == HRES - 1 || v == 0 || v == VRES - 1) return 0;
        case (sel)
            3'd1: begin
                if (k != IMG_IMPULSE) return img(k, h, v);
                if (ah == 0 && av == 0) return 63;
                if (ah + av == 1) return 31;
                if (ah == 1 && av == 1) return 15;
                return 0;
            end
            3'd2: begin
                if (k == IMG_IMPULSE) return (ah == 0 && av == 0) ? 255 : 0;
                if (k == IMG_INV_IMPULSE) return (ah == 0 && av == 0) ? 0 : 255;
                return img(k, h, v);
            end
            3'd3, 3'd5: return (k == IMG_RAMP) ? 80 : 0;
            3'd4:       return 0;
            default:    return img(k, h, v);
        endcase
    endfunction

    task automatic beat(input img_e k, input int h, input int v);
        @(posedge clk_in); #1;
        if (h == 0 && v == 0) frame_sel = sel_in;
        data_in[0]    = (v > 0) ? 8'(img(k, h, v - 1)) : 8'd0;
        data_in[1]    = 8'(img(k, h, v));
        data_in[2]    = (v < VRES - 1) ? 8'(img(k, h, v + 1)) : 8'd0;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        data_valid_in = 1'b1;
        if (h >= 1) sb.push_back('{h - 1, v, expect_px(k, frame_sel, h - 1, v), cyc + 4});
        if (h == HRES - 1) sb.push_back('{HRES - 1, v, 0, cyc + 5});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in); #1;
            data_valid_in = 1'b0;
        end
    endtask

    task automatic frame(input img_e k, input int gap_max, input int sel_row,
                         input logic [2:0] sel_new, input int n_beats);
        for (int v = 0; v < VRES; v++) begin
            for (int h = 0; h < HRES; h++) begin
                if (v * HRES + h >= n_beats) return;
                if (v == sel_row && h == 0) sel_in = sel_new;
                beat(k, h, v);
                if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
            end
        end
    endtask

    task automatic drain(input string name);
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_in);
        check(name, sb.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, int'(data_valid_out), 0);
        check({tag, "_pix"},   int'(pixel_out), 0);
        check({tag, "_h"},     int'(hcount_out), 0);
        check({tag, "_v"},     int'(vcount_out), 0);
    endtask

    always @(negedge clk_in) begin
        if (data_valid_out) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("pix(%0d,%0d)", mon_e.h, mon_e.v), int'(pixel_out), mon_e.pix);
                check($sformatf("hcount(%0d,%0d)", mon_e.h, mon_e.v), int'(hcount_out), mon_e.h);
                check($sformatf("vcount(%0d,%0d)", mon_e.h, mon_e.v), int'(vcount_out), mon_e.v);
                check($sformatf("cycle(%0d,%0d)", mon_e.h, mon_e.v), cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam int FULL = HRES * VRES;

    initial begin
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        data_in       = '0;
        hcount_in     = '0;
        vcount_in     = '0;
        sel_in        = 3'd0;
        frame_sel     = 3'd0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_zero_outputs("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Identity on a constant frame: one output per column, HRES*VRES per frame
        sel_in = 3'd0;
        n_mark = n_out;
        frame(IMG_CONST100, 0, -1, 3'd0, FULL);
        drain("drain_identity");
        check("identity_count", n_out - n_mark, FULL);

        // Gaussian: flat and impulse
        sel_in = 3'd1;
        frame(IMG_FLAT80, 0, -1, 3'd0, FULL);
        frame(IMG_IMPULSE, 0, -1, 3'd0, FULL);
        drain("drain_gauss");

        // Sobel on a horizontal ramp
        sel_in = 3'd3;
        frame(IMG_RAMP, 0, -1, 3'd0, FULL);
        sel_in = 3'd4;
        frame(IMG_RAMP, 0, -1, 3'd0, FULL);
        sel_in = 3'd5;
        frame(IMG_RAMP, 0, -1, 3'd0, FULL);
        drain("drain_sobel");

        // Sharpen saturating high and low
        sel_in = 3'd2;
        frame(IMG_IMPULSE, 0, -1, 3'd0, FULL);
        frame(IMG_INV_IMPULSE, 0, -1, 3'd0, FULL);
        drain("drain_sharpen");

        // Random gaps in the input stream
        sel_in = 3'd1;
        frame(IMG_IMPULSE, 3, -1, 3'd0, FULL);
        frame(IMG_RAMP, 2, -1, 3'd0, FULL);
        drain("drain_gaps");

        // Kernel change mid-frame takes effect only at the next frame
        sel_in = 3'd0;
        frame(IMG_IMPULSE, 0, 2, 3'd1, FULL);
        frame(IMG_IMPULSE, 0, -1, 3'd0, FULL);
        sel_in = 3'd6;
        frame(IMG_IMPULSE, 0, -1, 3'd0, FULL);
        sel_in = 3'd7;
        frame(IMG_RAMP, 0, -1, 3'd0, FULL);
        drain("drain_sel");

        // Reset mid-line drops in-flight beats
        sel_in = 3'd1;
        frame(IMG_IMPULSE, 0, -1, 3'd0, 2 * HRES + 5);
        @(posedge clk_in); #1;
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        @(posedge clk_in); #1;
        sb.delete();
        @(negedge clk_in);
        check_zero_outputs("midreset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle(8);
        sel_in = 3'd0;
        n_mark = n_out;
        frame(IMG_CONST100, 0, -1, 3'd0, FULL);
        drain("drain_after_reset");
        check("after_reset_count", n_out - n_mark, FULL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
